// File: rtl/shift_tx_pkg.sv
// Shared types and sizing helpers for the shift_tx_ctrl serial transmitter.
package shift_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  function automatic int cnt_width(input int width_p);
    return $clog2(width_p);
  endfunction

endpackage

// File: rtl/shift_tx_if.sv
// Word-in / bit-out handshake bundle; slave is the transmitter's view, master the environment's.
interface shift_tx_if #(
  parameter int width_p = 8
);
  logic               valid_i;
  logic               ready_o;
  logic [width_p-1:0] data_i;
  logic               valid_o;
  logic               ready_i;
  logic               data_o;
  logic               last_o;
  logic               busy_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, last_o, busy_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, busy_o
  );
endinterface

// File: rtl/shift_tx_ctrl_bit_down_counter.sv
// Loadable down-counter that saturates at zero; flags zero and one for terminal-beat detection.
module bit_down_counter #(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load,
  input  logic               en,
  input  logic [width_p-1:0] load_val,
  output logic               zero_o,
  output logic               one_o
);

  logic [width_p-1:0] cnt_r;

  // Count register: load wins, decrement only while nonzero so it never wraps.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - width_p'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero_o = (cnt_r == '0);
  assign one_o  = (cnt_r == width_p'(1));

endmodule

// File: rtl/shift_tx_ctrl.sv
// MSB-first parallel-to-serial transmitter with per-bit backpressure.
// Define SHIFT_TX_PARITY_EN to append an even-parity beat after the data bits.
module shift_tx_ctrl
  import shift_tx_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic      clk_i,
  input  logic      reset_i,
  shift_tx_if.slave bus
);

  localparam int                  cnt_w_lp    = cnt_width(width_p);
  localparam logic [cnt_w_lp-1:0] cnt_load_lp = cnt_w_lp'(width_p - 1);

  state_e             state_r;
  logic [width_p-1:0] shreg_r;
  logic               ready_r;
  logic               valid_r;
  logic               last_r;
  logic               load_s;
  logic               beat_s;
  logic               cnt_en_s;
  logic               zero_s;
  logic               one_s;

`ifdef SHIFT_TX_PARITY_EN
  logic               par_r;

  function automatic logic even_parity(input logic [width_p-1:0] word);
    return ^word;
  endfunction
`endif

  // ready_r is high only in IDLE, so it doubles as the state qualifier for a load.
  assign load_s   = bus.valid_i & ready_r;
  assign beat_s   = valid_r & bus.ready_i;
  assign cnt_en_s = beat_s & (state_r == SHIFT);

  bit_down_counter #(
    .width_p (cnt_w_lp)
  ) u_bit_cnt (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load     (load_s),
    .en       (cnt_en_s),
    .load_val (cnt_load_lp),
    .zero_o   (zero_s),
    .one_o    (one_s)
  );

  // Sequencer: the outgoing bit is always shreg_r MSB, so the parity bit is parked there too.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      shreg_r <= '0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            state_r <= SHIFT;
            shreg_r <= bus.data_i;
            ready_r <= 1'b0;
            valid_r <= 1'b1;
            last_r  <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
            par_r   <= even_parity(bus.data_i);
`endif
          end else begin
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
          end
        end
        SHIFT: begin
          if (beat_s && zero_s) begin
`ifdef SHIFT_TX_PARITY_EN
            state_r <= PARITY;
            shreg_r <= {par_r, {(width_p-1){1'b0}}};
            last_r  <= 1'b1;
`else
            state_r <= IDLE;
            shreg_r <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
`endif
          end else if (beat_s) begin
            shreg_r <= {shreg_r[width_p-2:0], 1'b0};
`ifdef SHIFT_TX_PARITY_EN
            last_r  <= 1'b0;
`else
            last_r  <= one_s;
`endif
          end else begin
            shreg_r <= shreg_r;
          end
        end
`ifdef SHIFT_TX_PARITY_EN
        PARITY: begin
          if (beat_s) begin
            state_r <= IDLE;
            shreg_r <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
          end else begin
            shreg_r <= shreg_r;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          shreg_r <= '0;
          ready_r <= 1'b0;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_r;
  assign bus.valid_o = valid_r;
  assign bus.data_o  = shreg_r[width_p-1];
  assign bus.last_o  = last_r;
  assign bus.busy_o  = valid_r;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Scoreboard bench for shift_tx_ctrl: stimulus queues expected beats, negedge monitors pop and compare.
module tb_shift_tx_ctrl;

`ifdef SHIFT_TX_PARITY_EN
  localparam int NB8 = 9;
  localparam int NB2 = 3;
`else
  localparam int NB8 = 8;
  localparam int NB2 = 2;
`endif

  logic clk;
  logic reset;
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   beats8 = 0;
  int   beats2 = 0;
  int   hs_cyc = 0;
  logic [1:0] q8[$];
  logic [1:0] q2[$];

  shift_tx_if #(.width_p(8)) bus8 ();
  shift_tx_if #(.width_p(2)) bus2 ();

  shift_tx_ctrl #(.width_p(8)) dut8 (.clk_i(clk), .reset_i(reset), .bus(bus8));
  shift_tx_ctrl #(.width_p(2)) dut2 (.clk_i(clk), .reset_i(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit transmitter: every completed beat must match the queue head.
  always @(negedge clk) begin
    logic [1:0] e;
    if (bus8.valid_o === 1'b1 && bus8.ready_i === 1'b1) begin
      beats8++;
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL beat8_unexpected: got data=%0b last=%0b expected no beat", bus8.data_o, bus8.last_o);
      end else begin
        e = q8.pop_front();
        chk("beat8_data", {31'd0, bus8.data_o}, {31'd0, e[1]});
        chk("beat8_last", {31'd0, bus8.last_o}, {31'd0, e[0]});
      end
    end
  end

  // Monitor for the 2-bit transmitter.
  always @(negedge clk) begin
    logic [1:0] e;
    if (bus2.valid_o === 1'b1 && bus2.ready_i === 1'b1) begin
      beats2++;
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL beat2_unexpected: got data=%0b last=%0b expected no beat", bus2.data_o, bus2.last_o);
      end else begin
        e = q2.pop_front();
        chk("beat2_data", {31'd0, bus2.data_o}, {31'd0, e[1]});
        chk("beat2_last", {31'd0, bus2.last_o}, {31'd0, e[0]});
      end
    end
  end

  task automatic push8(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
`ifdef SHIFT_TX_PARITY_EN
      q8.push_back({w[i], 1'b0});
`else
      q8.push_back({w[i], (i == 0) ? 1'b1 : 1'b0});
`endif
    end
`ifdef SHIFT_TX_PARITY_EN
    q8.push_back({^w, 1'b1});
`endif
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send8(input logic [7:0] w);
    int n;
    n = 0;
    push8(w);
    while (bus8.ready_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL send8_timeout: ready_o=%0b expected 1", bus8.ready_o);
    end
    bus8.valid_i = 1'b1;
    bus8.data_i  = w;
    @(posedge clk); #1;
    hs_cyc = cyc;
    bus8.valid_i = 1'b0;
  endtask

  task automatic wait_beats8(input int n);
    int k;
    k = 0;
    while (beats8 < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (beats8 < n) begin
      total++; bad++;
      $display("FAIL wait_beats8_timeout: beats=%0d expected %0d", beats8, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, bus8.ready_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus8.valid_o}, 32'd0);
    chk({tag, "_data"},  {31'd0, bus8.data_o},  32'd0);
    chk({tag, "_last"},  {31'd0, bus8.last_o},  32'd0);
    chk({tag, "_busy"},  {31'd0, bus8.busy_o},  32'd0);
  endtask

  initial begin
    int base;
    int c1;
    int k;
    reset = 1'b1;
    bus8.valid_i = 1'b0; bus8.data_i = 8'h00; bus8.ready_i = 1'b1;
    bus2.valid_i = 1'b0; bus2.data_i = 2'b00; bus2.ready_i = 1'b1;
    #1;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, bus8.ready_o}, 32'd1);

    // A5: first bit one cycle after handshake, ready back right after the last beat.
    base = beats8;
    send8(8'hA5);
    chk("first_bit_valid", {31'd0, bus8.valid_o}, 32'd1);
    chk("first_bit_data",  {31'd0, bus8.data_o},  32'd1);
    chk("busy_in_flight",  {31'd0, bus8.busy_o},  32'd1);
    chk("ready_in_flight", {31'd0, bus8.ready_o}, 32'd0);
    wait_beats8(base + NB8);
    chk("ready_after_word", {31'd0, bus8.ready_o}, 32'd1);
    chk("idle_after_word",  {31'd0, bus8.valid_o}, 32'd0);

    // Back-to-back A5 then 01: handshakes are one word period apart.
    base = beats8;
    send8(8'hA5);
    c1 = hs_cyc;
    send8(8'h01);
    chk("word_period", hs_cyc - c1, NB8 + 1);
    wait_beats8(base + 2 * NB8);

    // C3 with three stalled cycles after the second beat.
    base = beats8;
    send8(8'hC3);
    wait_beats8(base + 2);
    bus8.ready_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_data",  {31'd0, bus8.data_o},  32'd0);
      chk("bp_valid", {31'd0, bus8.valid_o}, 32'd1);
    end
    bus8.ready_i = 1'b1;
    wait_beats8(base + NB8);

    // FF with a competing 00 word offered mid-shift.
    base = beats8;
    send8(8'hFF);
    bus8.valid_i = 1'b1;
    bus8.data_i  = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    bus8.valid_i = 1'b0;
    wait_beats8(base + NB8);
    repeat (3) begin @(posedge clk); #1; end
    chk("ignored_word_idle", {31'd0, bus8.busy_o}, 32'd0);

    // F0 aborted by asynchronous reset after beat 3, then 0F sent cleanly.
    base = beats8;
    send8(8'hF0);
    wait_beats8(base + 3);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    q8.delete();
    @(posedge clk); #1;
    chk("ready_held_in_reset", {31'd0, bus8.ready_o}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_abort", {31'd0, bus8.ready_o}, 32'd1);
    base = beats8;
    send8(8'h0F);
    wait_beats8(base + NB8);

    // Minimum width: 2'b10.
    q2.push_back(2'b10);
`ifdef SHIFT_TX_PARITY_EN
    q2.push_back(2'b00);
    q2.push_back(2'b11);
`else
    q2.push_back(2'b01);
`endif
    bus2.valid_i = 1'b1;
    bus2.data_i  = 2'b10;
    @(posedge clk); #1;
    bus2.valid_i = 1'b0;
    k = 0;
    while (beats2 < NB2 && k < 50) begin @(posedge clk); #1; k++; end
    chk("w2_beats", beats2, NB2);
    chk("w2_ready_after", {31'd0, bus2.ready_o}, 32'd1);

    repeat (4) begin @(posedge clk); #1; end
    chk("q8_drained", q8.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
